// File: rtl/circle_lines_stream.sv
// ============================================================================
// circle_lines_stream
// Filled-circle rasteriser: emits horizontal spans (x0,y0,x1,y1) from the
// integer midpoint algorithm over a ready/valid stream.
// Optional build macro: CIRCLE_LINES_STREAM_DEDUP_EN (skip duplicate spans).
// Rev 1.0 - initial parametrised streaming release
// ============================================================================
`default_nettype none

module circle_lines_stream #(
   parameter int WIDTH = 32,
   parameter int DW    = WIDTH + 4
) (
   input  logic                    _clock,
   input  logic                    _reset_n,
   input  logic                    _start,
   input  logic signed [WIDTH-1:0] centre_x,
   input  logic signed [WIDTH-1:0] centre_y,
   input  logic signed [WIDTH-1:0] radius,
   input  logic                    _ready,
   output logic                    _valid,
   output logic signed [WIDTH-1:0] _out0,
   output logic signed [WIDTH-1:0] _out1,
   output logic signed [WIDTH-1:0] _out2,
   output logic signed [WIDTH-1:0] _out3,
   output logic                    _busy,
   output logic                    _done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_EMIT   = 3'd2,
      S_STEP   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic signed [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
   logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic signed [DW-1:0]    d_q, d_d;
   logic [1:0]              k_q, k_d;
   logic                    valid_q, valid_d, busy_q, busy_d, done_q, done_d;
   logic signed [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;

   logic [3:1]              elig_w;
   logic                    next_ok_w;
   logic [1:0]              next_k_w, load_k_w;
   logic signed [WIDTH-1:0] half_w, offs_w, x0_w, x1_w, yy_w;
   logic signed [DW-1:0]    xe_w, ye_w, re_w;

   // Sign-extended copies for the decision-variable arithmetic
   assign xe_w = {{(DW-WIDTH){x_q[WIDTH-1]}}, x_q};
   assign ye_w = {{(DW-WIDTH){y_q[WIDTH-1]}}, y_q};
   assign re_w = {{(DW-WIDTH){radius[WIDTH-1]}}, radius};

   // Which of spans 1..3 of the current iteration are worth emitting
   always_comb begin
`ifdef CIRCLE_LINES_STREAM_DEDUP_EN
      elig_w[1] = (y_q != '0);
      elig_w[2] = (x_q != y_q);
      elig_w[3] = (x_q != '0) && (x_q != y_q);
`else
      elig_w    = 3'b111;
`endif
   end

   // Lowest eligible span index after the one currently presented
   always_comb begin
      next_ok_w = 1'b1;
      next_k_w  = 2'd3;
      if (k_q == 2'd0 && elig_w[1]) begin
         next_k_w = 2'd1;
      end else if (k_q <= 2'd1 && elig_w[2]) begin
         next_k_w = 2'd2;
      end else if (k_q != 2'd3 && elig_w[3]) begin
         next_k_w = 2'd3;
      end else begin
         next_ok_w = 1'b0;
      end
   end

   assign load_k_w = (state_q == S_EMIT) ? next_k_w : 2'd0;

   // Span geometry: k[1] swaps the roles of x and y, k[0] mirrors about cy
   always_comb begin
      half_w = load_k_w[1] ? y_q : x_q;
      offs_w = load_k_w[1] ? x_q : y_q;
      x0_w   = cx_q - half_w;
      x1_w   = cx_q + half_w;
      yy_w   = load_k_w[0] ? (cy_q - offs_w) : (cy_q + offs_w);
   end

   // Next-state and output logic of the rasteriser sequencer
   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      x_d     = x_q;
      y_d     = y_q;
      d_d     = d_q;
      k_d     = k_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out0_d  = out0_q;
      out1_d  = out1_q;
      out2_d  = out2_q;
      case (state_q)
         S_IDLE: begin
            if (_start) begin
               cx_d    = centre_x;
               cy_d    = centre_y;
               x_d     = '0;
               y_d     = radius;
               d_d     = DW'(3) - (re_w + re_w);
               busy_d  = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (y_q >= x_q) begin
               k_d     = 2'd0;
               valid_d = 1'b1;
               out0_d  = x0_w;
               out1_d  = yy_w;
               out2_d  = x1_w;
               state_d = S_EMIT;
            end else begin
               state_d = S_FINISH;
            end
         end
         S_EMIT: begin
            if (valid_q && _ready) begin
               if (next_ok_w) begin
                  k_d    = next_k_w;
                  out0_d = x0_w;
                  out1_d = yy_w;
                  out2_d = x1_w;
               end else begin
                  valid_d = 1'b0;
                  state_d = S_STEP;
               end
            end
         end
         S_STEP: begin
            if (d_q > 0) begin
               d_d = d_q + ((xe_w - ye_w) <<< 2) + DW'(10);
               y_d = y_q - WIDTH'(1);
            end else begin
               d_d = d_q + (xe_w <<< 2) + DW'(6);
            end
            x_d     = x_q + WIDTH'(1);
            state_d = S_CHECK;
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any job in flight
   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         state_q <= S_IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         d_q     <= '0;
         k_q     <= 2'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out0_q  <= '0;
         out1_q  <= '0;
         out2_q  <= '0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         x_q     <= x_d;
         y_q     <= y_d;
         d_q     <= d_d;
         k_q     <= k_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
      end
   end

   assign _valid = valid_q;
   assign _out0  = out0_q;
   assign _out1  = out1_q;
   assign _out2  = out2_q;
   assign _out3  = out1_q;
   assign _busy  = busy_q;
   assign _done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_circle_lines_stream.sv
// ============================================================================
// tb_circle_lines_stream
// Directed self-checking bench for circle_lines_stream (WIDTH=32).
// Honours CIRCLE_LINES_STREAM_DEDUP_EN for the expected span lists.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_circle_lines_stream;

`ifdef CIRCLE_LINES_STREAM_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic clk, rst_n, st, rdy;
   logic signed [31:0] cxi, cyi, rad;
   logic v, busy, done;
   logic signed [31:0] o0, o1, o2, o3;

   int n_run, n_fail;

   logic [127:0] cap_q[$];
   int cap_done_c, cap_first_v, cap_unstable, cap_y1_bad, cap_busy_bad;

   circle_lines_stream #(.WIDTH(32)) dut (
      ._clock(clk), ._reset_n(rst_n), ._start(st),
      .centre_x(cxi), .centre_y(cyi), .radius(rad),
      ._ready(rdy), ._valid(v),
      ._out0(o0), ._out1(o1), ._out2(o2), ._out3(o3),
      ._busy(busy), ._done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] sp(input int a, input int b, input int c, input int d);
      return {32'(a), 32'(b), 32'(c), 32'(d)};
   endfunction

   // Called at posedge+1; leaves the bench at posedge+1 of the CHECK cycle
   task automatic start_job(input int ax, input int ay, input int ar);
      cxi = ax; cyi = ay; rad = ar; st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
   endtask

   // Records handshaken spans; cycle 1 is the cycle after the accepting edge
   task automatic capture(input int rmode, input int budget);
      logic [127:0] prev, cur;
      logic hold;
      logic [31:0] lfsr;
      cap_q.delete();
      cap_done_c = -1; cap_first_v = -1; cap_unstable = 0;
      cap_y1_bad = 0; cap_busy_bad = 0;
      lfsr = 32'hACE1_1234; hold = 1'b0; prev = '0;
      for (int c = 1; c <= budget; c++) begin
         if (rmode == 0) rdy = 1'b1;
         else begin
            lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            rdy  = lfsr[3];
         end
         cur = {o0, o1, o2, o3};
         if (hold && cur != prev) cap_unstable++;
         if (v && o3 !== o1) cap_y1_bad++;
         if (v && cap_first_v < 0) cap_first_v = c;
         if (v && rdy) cap_q.push_back(cur);
         hold = v && !rdy;
         prev = cur;
         if (done) begin
            cap_done_c = c;
            break;
         end
         if (!busy) cap_busy_bad++;
         @(posedge clk); #1;
      end
      rdy = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; st = 1'b0; rdy = 1'b0; cxi = 0; cyi = 0; rad = 0;
      repeat (3) @(posedge clk);
      #1;
      n_run++; if (v !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", v); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_run++; if ({o0, o1, o2, o3} !== 128'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", {o0, o1, o2, o3}); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_r0;
      int want_n;
      start_job(23, 17, 0);
      capture(0, 100);
      want_n = DEDUP ? 1 : 4;
      n_run++; if (cap_q.size() != want_n) begin n_fail++; $display("FAIL r0_count: got %0d want %0d", cap_q.size(), want_n); end
      foreach (cap_q[i]) begin
         n_run++; if (cap_q[i] !== sp(23, 17, 23, 17)) begin n_fail++; $display("FAIL r0_span%0d: got %h want %h", i, cap_q[i], sp(23, 17, 23, 17)); end
      end
      n_run++; if (cap_done_c != (DEDUP ? 6 : 9)) begin n_fail++; $display("FAIL r0_done_cycle: got %0d want %0d", cap_done_c, DEDUP ? 6 : 9); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL r0_busy_at_done: got %b want 0", busy); end
      n_run++; if (cap_busy_bad != 0) begin n_fail++; $display("FAIL r0_busy_during: got %0d low cycles want 0", cap_busy_bad); end
      @(posedge clk); #1;
      n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL r0_done_width: got %b want 0", done); end
   endtask

   task automatic test_r1;
      logic [127:0] exp_q[$];
      exp_q = '{sp(23, 18, 23, 18), sp(23, 16, 23, 16), sp(22, 17, 24, 17), sp(22, 17, 24, 17)};
      if (DEDUP) exp_q.delete(3);
      start_job(23, 17, 1);
      capture(0, 100);
      n_run++; if (cap_q.size() != exp_q.size()) begin n_fail++; $display("FAIL r1_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         n_run++; if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL r1_span%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
      end
      n_run++; if (cap_done_c != (DEDUP ? 8 : 9)) begin n_fail++; $display("FAIL r1_done_cycle: got %0d want %0d", cap_done_c, DEDUP ? 8 : 9); end
      @(posedge clk); #1;
   endtask

   function automatic void r5_table(ref logic [127:0] q[$]);
      q = '{sp(23, 22, 23, 22), sp(23, 12, 23, 12), sp(18, 17, 28, 17), sp(18, 17, 28, 17),
            sp(22, 22, 24, 22), sp(22, 12, 24, 12), sp(18, 18, 28, 18), sp(18, 16, 28, 16),
            sp(21, 22, 25, 22), sp(21, 12, 25, 12), sp(18, 19, 28, 19), sp(18, 15, 28, 15),
            sp(20, 21, 26, 21), sp(20, 13, 26, 13), sp(19, 20, 27, 20), sp(19, 14, 27, 14)};
      if (DEDUP) q.delete(3);
   endfunction

   task automatic test_r5;
      logic [127:0] exp_q[$];
      r5_table(exp_q);
      start_job(23, 17, 5);
      capture(0, 100);
      n_run++; if (cap_q.size() != exp_q.size()) begin n_fail++; $display("FAIL r5_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         n_run++; if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL r5_span%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
      end
      n_run++; if (cap_first_v != 2) begin n_fail++; $display("FAIL r5_first_valid: got cycle %0d want 2", cap_first_v); end
      n_run++; if (cap_done_c != (DEDUP ? 26 : 27)) begin n_fail++; $display("FAIL r5_done_cycle: got %0d want %0d", cap_done_c, DEDUP ? 26 : 27); end
      n_run++; if (cap_y1_bad != 0) begin n_fail++; $display("FAIL r5_out3_eq_out1: got %0d bad cycles want 0", cap_y1_bad); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      logic [127:0] exp_q[$];
      r5_table(exp_q);
      start_job(23, 17, 5);
      capture(1, 400);
      n_run++; if (cap_done_c < 0) begin n_fail++; $display("FAIL bp_done: got no done within budget want done"); end
      n_run++; if (cap_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         n_run++; if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_span%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
      end
      n_run++; if (cap_unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", cap_unstable); end
      @(posedge clk); #1;
   endtask

   task automatic test_negative;
      logic saw_v;
      int done_at;
      logic [127:0] exp_q[$];
      exp_q = '{sp(23, 18, 23, 18), sp(23, 16, 23, 16), sp(22, 17, 24, 17), sp(22, 17, 24, 17)};
      if (DEDUP) exp_q.delete(3);
      saw_v = 1'b0; done_at = -1;
      start_job(23, 17, -3);
      for (int c = 1; c <= 3; c++) begin
         // Start pulses while busy must be ignored; the one in the done cycle is accepted
         st = 1'b1; cxi = 23; cyi = 17; rad = (c < 3) ? 5 : 1;
         if (v) saw_v = 1'b1;
         if (done && done_at < 0) done_at = c;
         if (c == 1) begin
            n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL neg_busy: got %b want 1", busy); end
         end
         @(posedge clk); #1;
      end
      st = 1'b0;
      n_run++; if (saw_v !== 1'b0) begin n_fail++; $display("FAIL neg_no_valid: got %b want 0", saw_v); end
      n_run++; if (done_at != 3) begin n_fail++; $display("FAIL neg_done_cycle: got %0d want 3", done_at); end
      capture(0, 100);
      n_run++; if (cap_first_v != 2) begin n_fail++; $display("FAIL neg_restart_first_valid: got %0d want 2", cap_first_v); end
      n_run++; if (cap_q.size() != exp_q.size()) begin n_fail++; $display("FAIL neg_restart_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         n_run++; if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL neg_restart_span%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int acc;
      logic found, saw_done;
      logic [127:0] exp_q[$];
      exp_q = '{sp(23, 18, 23, 18), sp(23, 16, 23, 16), sp(22, 17, 24, 17), sp(22, 17, 24, 17)};
      if (DEDUP) exp_q.delete(3);
      rdy = 1'b1; acc = 0; found = 1'b0; saw_done = 1'b0;
      start_job(23, 17, 5);
      for (int c = 0; c < 60 && !found; c++) begin
         if (v) begin
            if (acc == 5) found = 1'b1;
            else acc++;
         end
         if (!found) begin @(posedge clk); #1; end
      end
      n_run++; if (!found) begin n_fail++; $display("FAIL rst_mid_sixth_span: got %0d spans want 6", acc); end
      #2 rst_n = 1'b0;
      #1;
      n_run++; if (v !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", v); end
      n_run++; if ({o0, o1, o2, o3} !== 128'd0) begin n_fail++; $display("FAIL rst_mid_outs: got %h want 0", {o0, o1, o2, o3}); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      for (int c = 0; c < 3; c++) begin
         if (done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         if (done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      n_run++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got %b want 0", saw_done); end
      start_job(23, 17, 1);
      capture(0, 100);
      n_run++; if (cap_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_mid_r1_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         n_run++; if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_mid_r1_span%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      n_run = 0; n_fail = 0;
      test_reset();
      test_r0();
      test_r1();
      test_r5();
      test_backpressure();
      test_negative();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
